pc_gen: RTL and testbench

Parametrised program-counter generator for the IFU front end. It owns the architectural fetch PC register and offers one fetch address per cycle to the fetch stage over a valid/ready handshake. It arbitrates trap and branch redirects and aligns redirect targets. It also supports a sticky halt. It sits between the EXU/WBU redirect sources and the instruction-fetch request logic, replacing the purely combinational next-PC select.

---
 rtl/pc_gen.sv | 114 +++++++++++
 tb/tb_pc_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator for the IFU front end.
// Holds the architectural fetch PC and offers one fetch address per cycle
// over a valid/ready handshake. It arbitrates trap and branch redirects,
// aligns their targets, and supports a sticky halt.
//
// Parameters:
//   ADDR_W    - fetch address width
//   RESET_VEC - first fetch address after reset
//   STEP      - sequential increment in bytes (2 or 4)
// Ports:
//   clk, rst                        - clock, async active-high reset
//   trap_valid_i / trap_pc_i        - trap redirect request and target
//   redirect_valid_i / redirect_pc_i- branch/jump redirect request and target
//   halt_i                          - stop fetching, sticky until reset
//   pc_ready_i                      - fetch stage accepts pc_o
//   pc_valid_o / pc_o               - fetch request and address
//   misalign_o                      - one-cycle pulse: last target had low bits set
//   halted_o                        - block is halted
//   redirect_cnt_o                  - saturating count of applied redirects
//                                     (only with PC_GEN_REDIRECT_CNT_EN defined)
module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h8000_0000),
  parameter int unsigned       STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  input  logic              pc_ready_i,
  output logic              pc_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              misalign_o,
  output logic              halted_o
`ifdef PC_GEN_REDIRECT_CNT_EN
  ,
  output logic [31:0]       redirect_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Bits cleared on redirect targets: [1:0] for STEP=4, [0] for STEP=2.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

  state_t            state;
  logic              target_apply;
  logic [ADDR_W-1:0] target_pc;

  // Trap outranks branch redirect.
  always_comb begin
    target_apply = trap_valid_i | redirect_valid_i;
    target_pc    = trap_valid_i ? trap_pc_i : redirect_pc_i;
  end

  // State machine, PC register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc_o       <= RESET_VEC;
      pc_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      halted_o   <= 1'b0;
`ifdef PC_GEN_REDIRECT_CNT_EN
      redirect_cnt_o <= 32'd0;
`endif
    end else begin
      misalign_o <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          // halt and redirects sampled here are ignored.
          state      <= ST_RUN;
          pc_valid_o <= 1'b1;
        end
        ST_RUN: begin
          if (halt_i) begin
            state      <= ST_HALTED;
            pc_valid_o <= 1'b0;
            halted_o   <= 1'b1;
          end else if (target_apply) begin
            pc_o       <= target_pc & ~LOW_MASK;
            misalign_o <= |(target_pc & LOW_MASK);
`ifdef PC_GEN_REDIRECT_CNT_EN
            if (redirect_cnt_o != 32'hFFFF_FFFF) begin
              redirect_cnt_o <= redirect_cnt_o + 32'd1;
            end
`endif
          end else if (pc_valid_o && pc_ready_i) begin
            // Wraps modulo 2^ADDR_W by construction.
            pc_o <= pc_o + STEP_INC;
          end
        end
        ST_HALTED: begin
          pc_valid_o <= 1'b0;
          halted_o   <= 1'b1;
        end
        default: begin
          state      <= ST_BOOT;
          pc_valid_o <= 1'b0;
          halted_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: spec model feeds a scoreboard queue,
// plus fixed checks from the test plan on three parameterisations.
`timescale 1ns/1ps
module tb_pc_gen;

  localparam logic [31:0] RST_VEC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        ready = 1'b0;

  logic        pc_valid, misalign, halted;
  logic [31:0] pc;
  logic        pc_valid2, misalign2, halted2;
  logic [31:0] pc2;
  logic        pc_valid16, misalign16, halted16;
  logic [15:0] pc16;
`ifdef PC_GEN_REDIRECT_CNT_EN
  logic [31:0] cnt, cnt2, cnt16;
`endif

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst(rst),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .halt_i(halt), .pc_ready_i(ready),
    .pc_valid_o(pc_valid), .pc_o(pc), .misalign_o(misalign), .halted_o(halted)
`ifdef PC_GEN_REDIRECT_CNT_EN
    , .redirect_cnt_o(cnt)
`endif
  );

  pc_gen #(.STEP(2)) u_dut_s2 (
    .clk(clk), .rst(rst),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .halt_i(halt), .pc_ready_i(ready),
    .pc_valid_o(pc_valid2), .pc_o(pc2), .misalign_o(misalign2), .halted_o(halted2)
`ifdef PC_GEN_REDIRECT_CNT_EN
    , .redirect_cnt_o(cnt2)
`endif
  );

  pc_gen #(.ADDR_W(16), .RESET_VEC(16'hFFFC), .STEP(4)) u_dut_16 (
    .clk(clk), .rst(rst),
    .trap_valid_i(1'b0), .trap_pc_i(16'h0000),
    .redirect_valid_i(1'b0), .redirect_pc_i(16'h0000),
    .halt_i(1'b0), .pc_ready_i(1'b1),
    .pc_valid_o(pc_valid16), .pc_o(pc16), .misalign_o(misalign16), .halted_o(halted16)
`ifdef PC_GEN_REDIRECT_CNT_EN
    , .redirect_cnt_o(cnt16)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        mis;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference model state (STEP=4 instance)
  typedef enum int {M_BOOT, M_RUN, M_HALTED} mstate_t;
  mstate_t     m_state;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = RST_VEC;
    m_cnt   = 32'd0;
  endtask

  // Called at a negedge: drive inputs, predict, clock, compare, return at next negedge.
  task automatic step(input logic tv, input logic [31:0] tp, input logic rv,
                      input logic [31:0] rp, input logic h, input logic rdy);
    exp_t e;
    exp_t g;
    logic mis;
    logic [31:0] tgt;
    trap_valid = tv; trap_pc = tp; redirect_valid = rv; redirect_pc = rp;
    halt = h; ready = rdy;
    mis = 1'b0;
    case (m_state)
      M_BOOT: m_state = M_RUN;
      M_RUN: begin
        if (h) m_state = M_HALTED;
        else if (tv || rv) begin
          tgt   = tv ? tp : rp;
          mis   = (tgt[1:0] != 2'b00);
          m_pc  = {tgt[31:2], 2'b00};
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end else if (rdy) m_pc = m_pc + 32'd4;
      end
      default: ;
    endcase
    e.valid  = (m_state == M_RUN);
    e.pc     = m_pc;
    e.mis    = mis;
    e.halted = (m_state == M_HALTED);
    e.cnt    = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check("pc_valid", 32'(pc_valid), 32'(g.valid));
    check("pc", pc, g.pc);
    check("misalign", 32'(misalign), 32'(g.mis));
    check("halted", 32'(halted), 32'(g.halted));
`ifdef PC_GEN_REDIRECT_CNT_EN
    check("redirect_cnt", cnt, g.cnt);
`endif
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RST_VEC);
    check("rst_valid", 32'(pc_valid), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc16", 32'(pc16), 32'h0000_FFFC);
    rst = 1'b0;
    #1;
    check("cycle0_valid", 32'(pc_valid), 32'd0);
    @(negedge clk);
    // Restart the alignment to a negedge after release for step().
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    // Wait: previous release produced a BOOT->RUN edge; re-synchronise cleanly.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from reset vector, ready high.
    step(0, '0, 0, '0, 0, 1);
    check("seq0", pc, 32'h8000_0000);
    check("w16_0", 32'(pc16), 32'h0000_FFFC);
    check("w16_valid", 32'(pc_valid16), 32'd1);
    step(0, '0, 0, '0, 0, 1);
    check("seq1", pc, 32'h8000_0004);
    check("w16_wrap", 32'(pc16), 32'h0000_0000);
    step(0, '0, 0, '0, 0, 1);
    check("seq2", pc, 32'h8000_0008);
    step(0, '0, 0, '0, 0, 1);
    step(0, '0, 0, '0, 0, 1);
    check("seq4", pc, 32'h8000_0010);

    // Stall three cycles.
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 0, 0);
    check("stall_hold", pc, 32'h8000_0010);
    step(0, '0, 0, '0, 0, 1);
    check("stall_adv", pc, 32'h8000_0014);

    // Trap and redirect in the same cycle: trap wins.
    step(1, 32'h8000_0100, 1, 32'h8000_0200, 0, 1);
    check("trap_prio", pc, 32'h8000_0100);

    // Misaligned redirect.
    step(0, '0, 1, 32'h8000_0203, 0, 1);
    check("mis_pc", pc, 32'h8000_0200);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("s2_pc", pc2, 32'h8000_0202);
    check("s2_mis", 32'(misalign2), 32'd1);
    step(0, '0, 0, '0, 0, 0);
    check("mis_clear", 32'(misalign), 32'd0);

    // Halt together with a redirect, then later redirects ignored.
    step(0, '0, 1, 32'h8000_0300, 1, 1);
    check("halt_pc", pc, 32'h8000_0200);
    check("halt_valid", 32'(pc_valid), 32'd0);
    check("halt_flag", 32'(halted), 32'd1);
    step(1, 32'h8000_0400, 0, '0, 0, 1);
    step(0, '0, 1, 32'h8000_0500, 0, 1);
    check("halt_sticky", pc, 32'h8000_0200);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, RST_VEC);
    check("arst_valid", 32'(pc_valid), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Handshake pending when reset hits.
    step(0, '0, 0, '0, 0, 1);
    step(0, '0, 0, '0, 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst2_pc", pc, RST_VEC);
    check("arst2_valid", 32'(pc_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic tv, rv, rdy;
      logic [31:0] tp, rp;
      tv  = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tp  = $urandom;
      rp  = $urandom;
      step(tv, tp, rv, rp, 0, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
